// File: rtl/core_periph_demux.sv
// core_periph_demux: routes core data accesses into the cluster peripheral windows, one outstanding access.
// Optional response timeout enabled by defining PERIPH_DEMUX_TIMEOUT_EN.
package core_periph_demux_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] add;
        logic        we;
        logic [31:0] data;
        logic [3:0]  be;
    } core_data_req_t;
    typedef struct packed {
        logic        gnt;
        logic [31:0] r_data;
        logic        r_valid;
    } core_data_rsp_t;
endpackage

module core_periph_demux
    import core_periph_demux_pkg::*;
#(
    parameter int          NB_SLV         = 12,
    parameter logic [31:0] PERIPH_BASE    = 32'h1020_0000,
    parameter int          WIN_LOG2       = 10,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  core_data_req_t               core_req_i,
    output core_data_rsp_t               core_rsp_o,
    output core_data_req_t [NB_SLV-1:0]  slv_req_o,
    input  core_data_rsp_t [NB_SLV-1:0]  slv_rsp_i,
    output logic                         err_o
);
    localparam int IW = $clog2(NB_SLV);

    typedef enum logic [1:0] {IDLE, WAIT_RSP, ERR_RSP} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, sel;
    logic [31:0]   win;
    logic          mapped;
`ifdef PERIPH_DEMUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Window 3 belongs to the event unit, which spans windows 2 and 3.
    always_comb begin
        win    = (core_req_i.add - PERIPH_BASE) >> WIN_LOG2;
        mapped = core_req_i.add >= PERIPH_BASE && win < 32'(NB_SLV - 1) && win != 32'd11;
        sel    = win == 32'd3 ? IW'(2) : IW'(win);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        slv_req_o  = '0;
        core_rsp_o = '0;
        err_o      = 1'b0;
`ifdef PERIPH_DEMUX_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (core_req_i.req && mapped) begin
                        slv_req_o[sel] = core_req_i;
                        core_rsp_o.gnt = slv_rsp_i[sel].gnt;
                        if (slv_rsp_i[sel].gnt) begin
                            state_d = WAIT_RSP;
                            idx_d   = sel;
`ifdef PERIPH_DEMUX_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end else if (core_req_i.req) begin
                        core_rsp_o.gnt = 1'b1;
                        state_d        = ERR_RSP;
                    end
                end
                WAIT_RSP: begin
                    core_rsp_o.r_valid = slv_rsp_i[idx_q].r_valid;
                    core_rsp_o.r_data  = slv_rsp_i[idx_q].r_data;
                    if (slv_rsp_i[idx_q].r_valid) begin
                        state_d = IDLE;
                    end
`ifdef PERIPH_DEMUX_TIMEOUT_EN
                    else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == CW'(TIMEOUT_CYCLES)) state_d = ERR_RSP;
                    end
`endif
                end
                ERR_RSP: begin
                    core_rsp_o.r_valid = 1'b1;
                    core_rsp_o.r_data  = 32'hBADA_CCE5;
                    err_o              = 1'b1;
                    state_d            = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
`ifdef PERIPH_DEMUX_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
`ifdef PERIPH_DEMUX_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_core_periph_demux.sv
// tb_core_periph_demux: random and directed accesses checked against an address-map reference model.
module tb_core_periph_demux;
    import core_periph_demux_pkg::*;
    localparam int          NB   = 12;
    localparam logic [31:0] BASE = 32'h1020_0000;
    localparam int          TO   = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    core_data_req_t          core_req_i;
    core_data_rsp_t          core_rsp_o;
    core_data_req_t [NB-1:0] slv_req_o;
    core_data_rsp_t [NB-1:0] slv_rsp_i;
    logic                    err_o;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    core_periph_demux #(.NB_SLV(NB), .PERIPH_BASE(BASE), .WIN_LOG2(10), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .core_req_i(core_req_i), .core_rsp_o(core_rsp_o),
        .slv_req_o(slv_req_o), .slv_rsp_i(slv_rsp_i), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference map: 1 KiB windows from BASE, last slot and beyond unmapped, window 3 aliases 2.
    function automatic int ref_slave(input logic [31:0] a);
        logic [31:0] w;
        if (a < BASE) return -1;
        w = (a - BASE) / 1024;
        if (w >= NB - 1 || w == 11) return -1;
        return w == 3 ? 2 : int'(w);
    endfunction

    function automatic int req_cnt(input int e);
        int n = 0;
        for (int i = 0; i < NB; i++) if (i != e && slv_req_o[i].req) n++;
        return n;
    endfunction

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic noise(input int e);
        for (int i = 0; i < NB; i++)
            if (i != e) slv_rsp_i[i] = '{gnt: 1'($urandom), r_data: $urandom, r_valid: 1'($urandom)};
    endtask

    task automatic xact(input logic [31:0] a, input int gd, input int rd);
        int e;
        logic [31:0] rdat;
        e    = ref_slave(a);
        rdat = $urandom;
        core_req_i = '{req: 1'b1, add: a, we: 1'($urandom), data: $urandom, be: 4'($urandom)};
        noise(e);
        if (e < 0) begin
            #1;
            chk("unmapped_gnt", core_rsp_o.gnt, 1);
            chk("unmapped_noreq", req_cnt(-1), 0);
            chk("idle_rvalid", core_rsp_o.r_valid, 0);
            step;
            core_req_i.req = 1'b0;
            noise(-1);
            #1;
            chk("err_rvalid", core_rsp_o.r_valid, 1);
            chk("err_rdata", core_rsp_o.r_data, 32'hBADA_CCE5);
            chk("err_pulse", err_o, 1);
            chk("err_gnt", core_rsp_o.gnt, 0);
            step;
            chk("err_end", err_o, 0);
            chk("err_end_rvalid", core_rsp_o.r_valid, 0);
        end else begin
            for (int c = 0; c <= gd; c++) begin
                slv_rsp_i[e].gnt     = (c == gd);
                slv_rsp_i[e].r_valid = 1'($urandom);
                #1;
                chk("route_req", slv_req_o[e].req, 1);
                chk("route_add", slv_req_o[e].add, a);
                chk("route_data", slv_req_o[e].data, core_req_i.data);
                chk("other_req", req_cnt(e), 0);
                chk("core_gnt", core_rsp_o.gnt, 32'(c == gd));
                chk("idle_rvalid", core_rsp_o.r_valid, 0);
                step;
                noise(e);
            end
            slv_rsp_i[e].gnt = 1'b0;
            for (int c = 0; c <= rd; c++) begin
                core_req_i.req        = 1'($urandom);
                slv_rsp_i[e].r_valid  = (c == rd);
                slv_rsp_i[e].r_data   = rdat;
                #1;
                chk("wait_gnt", core_rsp_o.gnt, 0);
                chk("wait_req", req_cnt(-1), 0);
                chk("rsp_valid", core_rsp_o.r_valid, 32'(c == rd));
                if (c == rd) chk("rsp_data", core_rsp_o.r_data, rdat);
                chk("no_err", err_o, 0);
                step;
                noise(e);
            end
            core_req_i.req       = 1'b0;
            slv_rsp_i[e].r_valid = 1'b0;
            #1;
            chk("post_rvalid", core_rsp_o.r_valid, 0);
            chk("post_rdata", core_rsp_o.r_data, 0);
        end
    endtask

    initial begin
        logic [31:0] a;
        core_req_i = '0;
        slv_rsp_i  = '0;
        core_req_i.req = 1'b1;
        core_req_i.add = BASE + 32'h400;
        slv_rsp_i[1].gnt = 1'b1;
        slv_rsp_i[1].r_valid = 1'b1;
        #2;
        chk("rst_gnt", core_rsp_o.gnt, 0);
        chk("rst_req", req_cnt(-1), 0);
        chk("rst_rvalid", core_rsp_o.r_valid, 0);
        chk("rst_err", err_o, 0);
        core_req_i = '0;
        slv_rsp_i  = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        step;

        xact(32'h1020_0400, 0, 0);
        xact(32'h1020_0C10, 0, 2);
        xact(32'h1020_2C00, 0, 0);
        xact(32'h1020_1000, 3, 1);
        xact(32'h101F_FFFC, 0, 0);

        core_req_i = '{req: 1'b1, add: 32'h1020_1400, we: 1'b0, data: 32'h0, be: 4'hF};
        slv_rsp_i[5].gnt = 1'b1;
        #1;
        step;
        slv_rsp_i[5].gnt = 1'b0;
        core_req_i.add   = 32'h1020_1800;
        slv_rsp_i[6].gnt = 1'b1;
        #1;
        chk("flight_gnt", core_rsp_o.gnt, 0);
        rst_i = 1'b1;
        slv_rsp_i[5].r_valid = 1'b1;
        #1;
        chk("arst_gnt", core_rsp_o.gnt, 0);
        chk("arst_req", req_cnt(-1), 0);
        chk("arst_rvalid", core_rsp_o.r_valid, 0);
        step;
        chk("arst_hold_rvalid", core_rsp_o.r_valid, 0);
        core_req_i.req = 1'b0;
        rst_i = 1'b0;
        #1;
        chk("late_rsp_ignored", core_rsp_o.r_valid, 0);
        step;
        chk("late_rsp_ignored2", core_rsp_o.r_valid, 0);
        slv_rsp_i = '0;
        xact(32'h1020_1800, 0, 0);

        core_req_i = '{req: 1'b1, add: 32'h1020_1800, we: 1'b1, data: 32'h55, be: 4'hF};
        slv_rsp_i[6].gnt = 1'b1;
        #1;
        step;
        core_req_i.req = 1'b0;
        slv_rsp_i[6].gnt = 1'b0;
`ifdef PERIPH_DEMUX_TIMEOUT_EN
        for (int c = 0; c < TO; c++) begin
            noise(6);
            #1;
            chk("to_wait_rvalid", core_rsp_o.r_valid, 0);
            step;
        end
        chk("to_rvalid", core_rsp_o.r_valid, 1);
        chk("to_rdata", core_rsp_o.r_data, 32'hBADA_CCE5);
        chk("to_err", err_o, 1);
        step;
        slv_rsp_i[6].r_valid = 1'b1;
        #1;
        chk("to_late_ignored", core_rsp_o.r_valid, 0);
        chk("to_late_err", err_o, 0);
        step;
        slv_rsp_i[6].r_valid = 1'b0;
        core_req_i.req = 1'b1;
        slv_rsp_i[6].gnt = 1'b1;
        #1;
        step;
        core_req_i.req = 1'b0;
        slv_rsp_i[6].gnt = 1'b0;
        for (int c = 0; c < TO; c++) begin
            slv_rsp_i[6].r_valid = (c == TO - 1);
            slv_rsp_i[6].r_data  = 32'h0000_1234;
            #1;
            chk("to_prio_rvalid", core_rsp_o.r_valid, 32'(c == TO - 1));
            chk("to_prio_err", err_o, 0);
            if (c == TO - 1) chk("to_prio_rdata", core_rsp_o.r_data, 32'h0000_1234);
            step;
        end
        slv_rsp_i[6].r_valid = 1'b0;
        #1;
        chk("to_prio_after_err", err_o, 0);
        chk("to_prio_after_rvalid", core_rsp_o.r_valid, 0);
`else
        for (int c = 0; c < 10; c++) begin
            noise(6);
            #1;
            chk("hold_rvalid", core_rsp_o.r_valid, 0);
            chk("hold_err", err_o, 0);
            step;
        end
        slv_rsp_i[6].r_valid = 1'b1;
        slv_rsp_i[6].r_data  = 32'h0000_1234;
        #1;
        chk("hold_rsp", core_rsp_o.r_valid, 1);
        chk("hold_rdata", core_rsp_o.r_data, 32'h0000_1234);
        step;
        slv_rsp_i[6].r_valid = 1'b0;
`endif
        step;

        for (int t = 0; t < 80; t++) begin
            case ($urandom % 5)
                0:       a = BASE - 32'd1 - 32'($urandom % 4096);
                1:       a = BASE + 32'd11264 + 32'($urandom % 1024);
                2:       a = BASE + 32'(12 + $urandom % 100) * 32'd1024 + 32'($urandom % 1024);
                default: a = BASE + 32'($urandom % 11) * 32'd1024 + 32'($urandom % 1024);
            endcase
            xact(a, int'($urandom % 4), int'($urandom % 4));
            step;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
